// File: rtl/ibex_predict_ctrl_if.sv
// ibex_predict_ctrl_if
// Bundles the fetch handshake, predictor sample, redirect, resolve and
// mispredict signals of the static branch predictor controller.
//   slave  : the controller (accepts fetch/resolve, produces redirect/mispredict)
//   master : the surrounding fetch/EX logic (or a testbench driving it)
// Signals:
//   fetch_valid_i/fetch_ready_o      fetch handshake
//   fetch_pc_i, fetch_rdata_i        instruction PC and word
//   fetch_cf_i                       instruction is a branch or jump
//   pred_taken_i, pred_pc_i          predictor outputs for the instruction
//   redirect_o, redirect_pc_o        registered prefetch redirect pulse
//   resolve_valid_i/taken_i/target_i in-order EX resolution of oldest cf
//   flush_i                          core-level flush
//   mispredict_o, mispredict_pc_o    registered mispredict pulse and fix-up PC
//   resolve_err_o                    sticky: resolve with nothing in flight
//   pred_cnt_o, mispred_cnt_o        saturating performance counters
interface ibex_predict_ctrl_if #(
  parameter int unsigned CntW = 16
);
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [31:0]     fetch_pc_i;
  logic [31:0]     fetch_rdata_i;
  logic            fetch_cf_i;
  logic            pred_taken_i;
  logic [31:0]     pred_pc_i;
  logic            redirect_o;
  logic [31:0]     redirect_pc_o;
  logic            resolve_valid_i;
  logic            resolve_taken_i;
  logic [31:0]     resolve_target_i;
  logic            flush_i;
  logic            mispredict_o;
  logic [31:0]     mispredict_pc_o;
  logic            resolve_err_o;
  logic [CntW-1:0] pred_cnt_o;
  logic [CntW-1:0] mispred_cnt_o;

  modport slave (
    input  fetch_valid_i, fetch_pc_i, fetch_rdata_i, fetch_cf_i,
           pred_taken_i, pred_pc_i,
           resolve_valid_i, resolve_taken_i, resolve_target_i, flush_i,
    output fetch_ready_o, redirect_o, redirect_pc_o,
           mispredict_o, mispredict_pc_o, resolve_err_o,
           pred_cnt_o, mispred_cnt_o
  );

  modport master (
    output fetch_valid_i, fetch_pc_i, fetch_rdata_i, fetch_cf_i,
           pred_taken_i, pred_pc_i,
           resolve_valid_i, resolve_taken_i, resolve_target_i, flush_i,
    input  fetch_ready_o, redirect_o, redirect_pc_o,
           mispredict_o, mispredict_pc_o, resolve_err_o,
           pred_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/ibex_predict_ctrl.sv
// ibex_predict_ctrl
// Sequencing controller for the static branch predictor in the fetch path.
// Accepted control-flow instructions push {taken, target, fallthrough} into an
// in-order prediction queue; a predicted-taken one also issues a registered
// redirect. EX resolves entries in order; a wrong direction or wrong target
// empties the queue and issues a registered mispredict with the corrected PC.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     ibex_predict_ctrl_if.slave (all handshake/data signals)
module ibex_predict_ctrl #(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  ibex_predict_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(Depth);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic [1:0] {RUN, REDIR, RECOV} state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthrough;
  } entry_t;

  state_e      state;
  entry_t      mem [Depth];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr, rd_ptr;

  logic        empty, full, resolve_hit, mispredict_now, fire, push;
  entry_t      head, new_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign resolve_hit    = bus.resolve_valid_i & ~empty;
  assign mispredict_now = resolve_hit &
                          ((bus.resolve_taken_i != head.taken) |
                           (bus.resolve_taken_i & head.taken &
                            (bus.resolve_target_i != head.target)));

  // rst_ni is included so ready is low throughout reset, before the first
  // edge has put the FSM into RUN.
  assign bus.fetch_ready_o = rst_ni & (state == RUN) & ~full &
                             ~bus.flush_i & ~mispredict_now;

  assign fire = bus.fetch_valid_i & bus.fetch_ready_o;
  assign push = fire & bus.fetch_cf_i;

  // Compressed instructions have rdata[1:0] != 2'b11.
  assign new_entry.taken       = bus.pred_taken_i;
  assign new_entry.target      = bus.pred_pc_i;
  assign new_entry.fallthrough = bus.fetch_pc_i +
                                 ((bus.fetch_rdata_i[1:0] == 2'b11) ? 32'd4 : 32'd2);

  // NOTE: queue storage has no reset; the pointers alone define which entries
  // are valid, so resetting the array would only add flops' worth of muxing.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= new_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every branch
  // below sees the pre-edge values of state and pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state             <= RUN;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      bus.redirect_o      <= 1'b0;
      bus.redirect_pc_o   <= '0;
      bus.mispredict_o    <= 1'b0;
      bus.mispredict_pc_o <= '0;
      bus.resolve_err_o   <= 1'b0;
      bus.pred_cnt_o      <= '0;
      bus.mispred_cnt_o   <= '0;
    end else if (bus.flush_i) begin
      // Flush dominates: drop everything in flight, no counting.
      state            <= RUN;
      rd_ptr           <= wr_ptr;
      bus.redirect_o   <= 1'b0;
      bus.mispredict_o <= 1'b0;
    end else begin
      state            <= RUN;
      bus.redirect_o   <= 1'b0;
      bus.mispredict_o <= 1'b0;

      if (bus.resolve_valid_i && empty) bus.resolve_err_o <= 1'b1;
      if (resolve_hit && bus.pred_cnt_o != CntMax)
        bus.pred_cnt_o <= bus.pred_cnt_o + CntW'(1);

      if (mispredict_now) begin
        // Every younger entry is wrong-path; overrides a redirect in flight.
        rd_ptr              <= wr_ptr;
        state               <= RECOV;
        bus.mispredict_o    <= 1'b1;
        bus.mispredict_pc_o <= bus.resolve_taken_i ? bus.resolve_target_i
                                                   : head.fallthrough;
        if (bus.mispred_cnt_o != CntMax)
          bus.mispred_cnt_o <= bus.mispred_cnt_o + CntW'(1);
      end else begin
        if (resolve_hit) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (push)        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (push && bus.pred_taken_i) begin
          state             <= REDIR;
          bus.redirect_o    <= 1'b1;
          bus.redirect_pc_o <= bus.pred_pc_i;
        end
      end
    end
  end
endmodule

// File: doc/ibex_predict_ctrl.md
# ibex_predict_ctrl

Sequencing controller for the static branch predictor in the Ibex fetch path. It accepts fetched instructions under a valid/ready handshake and samples the predictor's combinational taken/target outputs. It issues registered redirects to the prefetch buffer and tracks in-flight control-flow predictions in an in-order queue. When EX resolves each branch or jump, it checks the outcome against the prediction and flushes with the corrected PC on a mispredict.

## Interface

- Depth, 4, prediction queue entries; power of 2, ≥2
- CntW, 16, width of saturating performance counters

- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset (sampled on clk_i rising edge)
- fetch_valid_i  in  1  fetch stage presents an instruction
- fetch_ready_o  out  1  controller accepts the instruction this cycle
- fetch_pc_i  in  32  PC of the presented instruction
- fetch_rdata_i  in  32  instruction word; compressed instructions occupy [15:0]
- fetch_cf_i  in  1  instruction is a branch or JAL/C.J/C.JAL
- pred_taken_i  in  1  predictor taken output for the presented instruction
- pred_pc_i  in  32  predictor target for the presented instruction
- redirect_o  out  1  one-cycle pulse: prefetch jumps to redirect_pc_o
- redirect_pc_o  out  32  predicted target
- resolve_valid_i  in  1  EX resolves the oldest control-flow instruction, in order
- resolve_taken_i  in  1  actual direction
- resolve_target_i  in  32  actual target when taken
- flush_i  in  1  core-level flush (exception/debug): discard all state
- mispredict_o  out  1  one-cycle pulse: pipeline must flush and refetch
- mispredict_pc_o  out  32  corrected PC
- resolve_err_o  out  1  sticky: resolve arrived with queue empty
- pred_cnt_o  out  CntW  resolved control-flow instructions, saturating
- mispred_cnt_o  out  CntW  mispredicts, saturating

## Operation

- Accept: fire = fetch_valid_i & fetch_ready_o. A non-cf fire has no effect. A cf fire pushes {pred_taken_i, pred_pc_i, fallthrough}.
- Fallthrough = fetch_pc_i + 4 if fetch_rdata_i[1:0]==2'b11, else + 2. All 32-bit adds wrap modulo 2^32.
- Redirect: a cf fire with pred_taken_i=1 registers redirect_o=1 and redirect_pc_o=pred_pc_i for the next cycle.
- Resolve: pops the queue head and increments pred_cnt_o.
- Mispredict condition: resolve_taken_i != head.taken, or both taken and resolve_target_i != head.target.
- Corrected PC = resolve_taken_i ? resolve_target_i : head.fallthrough.
- On mispredict: the queue is emptied (all younger entries are wrong-path), mispred_cnt_o increments, and mispredict_o/mispredict_pc_o are registered for the next cycle.
- Counters saturate at all-ones and never wrap.
- FSM states:
  - RUN: normal operation.
  - REDIR: one cycle with redirect_o=1. The fetch slot after a predicted-taken instruction is wrong-path, so fetch_ready_o=0. Resolves are still processed.
  - RECOV: one cycle with mispredict_o=1. fetch_ready_o=0. Returns to RUN.
- FSM transitions:
  - RUN → REDIR on a predicted-taken cf fire.
  - RUN or REDIR → RECOV on a mispredict.
  - REDIR → RUN otherwise.
- fetch_ready_o = (state==RUN) & ~full & ~flush_i & ~mispredict_now. mispredict_now is the combinational mispredict condition in the current cycle.
- Priority: flush_i > mispredict > push/redirect.
  - flush_i empties the queue, cancels pending redirect and mispredict outputs, and forces RUN. No mispredict_o is generated, and counters are not incremented by a simultaneous resolve.
  - A mispredict in the same cycle as a fetch fire: impossible by the ready equation. A registered redirect in flight is overridden (REDIR → RECOV).
- Simultaneous push and correct pop: both take effect and occupancy is unchanged. Full blocks push even when a pop occurs in the same cycle (no bypass).
- Resolve with queue empty: ignored (no pop, no counter change) and sets resolve_err_o, which clears only on reset.

## Timing

- Reset values (rst_ni low at a rising edge):
  - state=RUN, queue empty, counters 0, resolve_err_o 0.
  - redirect_o 0, redirect_pc_o 0, mispredict_o 0, mispredict_pc_o 0.
  - fetch_ready_o is 0 while rst_ni is low and 1 in the first cycle after release.
- Reset during REDIR or RECOV aborts the pulse in the following cycle.
- Predicted-taken fire in cycle N → redirect_o=1 in N+1, fetch_ready_o=0 in N+1, earliest next accept in N+2.
- Mispredicting resolve in cycle N → mispredict_o=1 in N+1, queue empty from N+1, fetch_ready_o=0 in N and N+1, earliest accept in N+2.
- Counters and resolve_err_o update one cycle after the triggering event.
- No combinational path from pred_* to redirect_*. fetch_ready_o depends combinationally on resolve_* and flush_i only.

## Test plan

- Reset: hold rst_ni low 3 cycles with random inputs → all outputs 0; after release fetch_ready_o=1, counters 0.
- Backward branch pc 0x100, pred_taken_i=1, pred_pc_i=0xF8 → redirect_o=1 / 0xF8 next cycle, ready=0 that cycle. Resolve taken 0xF8 → no mispredict, pred_cnt_o=1, mispred_cnt_o=0.
- Compressed forward branch pc 0x200, pred_taken_i=0; resolve taken target 0x240 → mispredict_o=1 / 0x240 next cycle, mispred_cnt_o=1, queue empty.
- 32-bit JAL pc 0x300 predicted taken; resolve not-taken → mispredict_pc_o=0x304. Same with a compressed instruction at 0x300 → 0x302.
- Push Depth=4 not-taken branches → fetch_ready_o=0. Resolve one correctly → ready=1 next cycle. Counter preloaded at 0xFFFF → stays 0xFFFF.
- flush_i concurrent with a mispredicting resolve → no mispredict_o, queue empty, counters unchanged. A later resolve on the empty queue → resolve_err_o=1 and stays set.
